// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared types and defaults for the clock-gating controller
//
// Contents:
//   cg_state_e            per-channel gating state (RUN, GATED, WAKE)
//   CG_WAKE_LAT_DEFAULT   default wake-up latency in clk_i cycles
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        GATED = 2'd1,
        WAKE  = 2'd2
    } cg_state_e;

    localparam int unsigned CG_WAKE_LAT_DEFAULT = 2;

endpackage

// File: rtl/cv32e40p_clock_gate.sv
// rtl/cv32e40p_clock_gate.sv - latch-based glitch-free clock gate cell
//
// Ports:
//   clk_i         free-running clock
//   en_i          gate enable, expected to change only after a clk_i rising edge
//   scan_cg_en_i  scan override, forces the clock running
//   clk_o         gated clock
module cv32e40p_clock_gate (
    input  logic clk_i,
    input  logic en_i,
    input  logic scan_cg_en_i,
    output logic clk_o
);

    logic clk_en;

    // Transparent while clk_i is low, so the enable is frozen for the whole
    // high phase and clk_o can never be truncated or spiked.
    always_latch begin
        if (clk_i == 1'b0) begin
            clk_en = en_i | scan_cg_en_i;
        end
    end

    assign clk_o = clk_i & clk_en;

endmodule

// File: rtl/cv32e40p_clock_gate_ch.sv
// rtl/cv32e40p_clock_gate_ch.sv - one auto-gated clock channel: FSM, idle counter, enable, gate cell
//
// Ports:
//   clk_i          free-running clock
//   rst_i          synchronous active-high reset
//   scan_cg_en_i   scan override passed to the gate cell only
//   idle_thresh_i  consecutive idle cycles before gating, 0 disables gating
//   act_i          channel activity (busy | force_on | wake_req)
//   ready_o        channel clock stable and usable (state RUN)
//   gated_o        registered enable is low
//   clk_o          gated clock
module cv32e40p_clock_gate_ch
    import cv32e40p_pkg::*;
#(
    parameter int unsigned IDLE_CNT_W = 8,
    parameter int unsigned WAKE_LAT   = CG_WAKE_LAT_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  scan_cg_en_i,
    input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
    input  logic                  act_i,
    output logic                  ready_o,
    output logic                  gated_o,
    output logic                  clk_o
);

    localparam logic [IDLE_CNT_W:0] WAKE_LAST = (IDLE_CNT_W+1)'(WAKE_LAT);

    cg_state_e             state_q, state_d;
    logic [IDLE_CNT_W-1:0] cnt_q, cnt_d;
    logic                  en_q, en_d;
    logic [IDLE_CNT_W:0]   cnt_inc;

    // One bit wider than the counter so cnt+1 never wraps in the compares.
    assign cnt_inc = {1'b0, cnt_q} + {{IDLE_CNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        case (state_q)
            RUN: begin
                if (act_i || (idle_thresh_i == '0)) begin
                    cnt_d = '0;
                end else if (cnt_inc >= {1'b0, idle_thresh_i}) begin
                    // A saturated counter yields cnt_inc = 2^W, which always
                    // hits here, so the counter can never wrap.
                    state_d = GATED;
                    en_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc[IDLE_CNT_W-1:0];
                end
            end
            GATED: begin
                if (act_i) begin
                    state_d = WAKE;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            WAKE: begin
                // Wake always runs to completion, activity is ignored here.
                if (cnt_inc == WAKE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc[IDLE_CNT_W-1:0];
                end
            end
            default: begin
                state_d = RUN;
                en_d    = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
            en_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
        end
    end

    assign ready_o = (state_q == RUN);
    assign gated_o = ~en_q;

    cv32e40p_clock_gate u_cg (
        .clk_i        (clk_i),
        .en_i         (en_q),
        .scan_cg_en_i (scan_cg_en_i),
        .clk_o        (clk_o)
    );

endmodule

// File: rtl/cv32e40p_clock_gate_ctrl.sv
// rtl/cv32e40p_clock_gate_ctrl.sv - multi-channel automatic clock-gating controller
//
// Ports:
//   clk_i          free-running clock
//   rst_i          synchronous active-high reset
//   scan_cg_en_i   scan override, forces every clk_o running
//   idle_thresh_i  shared idle threshold, 0 disables auto-gating
//   busy_i         per-channel activity
//   force_on_i     per-channel hold-on, same effect as busy_i
//   wake_req_i     per-channel explicit wake request
//   ready_o        per-channel clock usable
//   gated_o        per-channel enable low
//   clk_o          per-channel gated clocks
module cv32e40p_clock_gate_ctrl
    import cv32e40p_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned IDLE_CNT_W = 8,
    parameter int unsigned WAKE_LAT   = CG_WAKE_LAT_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  scan_cg_en_i,
    input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
    input  logic [NUM_CH-1:0]     busy_i,
    input  logic [NUM_CH-1:0]     force_on_i,
    input  logic [NUM_CH-1:0]     wake_req_i,
    output logic [NUM_CH-1:0]     ready_o,
    output logic [NUM_CH-1:0]     gated_o,
    output logic [NUM_CH-1:0]     clk_o
);

    logic [NUM_CH-1:0] act;

    assign act = busy_i | force_on_i | wake_req_i;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cv32e40p_clock_gate_ch #(
            .IDLE_CNT_W (IDLE_CNT_W),
            .WAKE_LAT   (WAKE_LAT)
        ) u_ch (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .scan_cg_en_i  (scan_cg_en_i),
            .idle_thresh_i (idle_thresh_i),
            .act_i         (act[c]),
            .ready_o       (ready_o[c]),
            .gated_o       (gated_o[c]),
            .clk_o         (clk_o[c])
        );
    end

endmodule

// File: tb/tb_cv32e40p_clock_gate_ctrl.sv
// tb/tb_cv32e40p_clock_gate_ctrl.sv - self-checking bench for cv32e40p_clock_gate_ctrl
module tb_cv32e40p_clock_gate_ctrl;

    localparam int NCH = 4;
    localparam int WL  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           scan;
    logic [7:0]     thr;
    logic [NCH-1:0] busy, force_on, wake, ready, gated, clk_g;

    int checks   = 0;
    int failures = 0;

    // Reference model: consecutive-idle count, gated flag, remaining wake cycles.
    bit m_gated [NCH];
    int m_idle  [NCH];
    int m_wake  [NCH];
    bit model_valid = 1'b0;

    cv32e40p_clock_gate_ctrl #(
        .NUM_CH     (NCH),
        .IDLE_CNT_W (8),
        .WAKE_LAT   (WL)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .scan_cg_en_i  (scan),
        .idle_thresh_i (thr),
        .busy_i        (busy),
        .force_on_i    (force_on),
        .wake_req_i    (wake),
        .ready_o       (ready),
        .gated_o       (gated),
        .clk_o         (clk_g)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model on the rising edge, check
    // clk_o in the high phase and ready/gated in the low phase.
    task automatic step(input logic r, input logic s, input logic [7:0] t,
                        input logic [NCH-1:0] b, input logic [NCH-1:0] f,
                        input logic [NCH-1:0] w);
        logic [NCH-1:0] prev_en, exp_rdy, exp_g;
        bit was_valid;
        bit act;
        rst = r; scan = s; thr = t; busy = b; force_on = f; wake = w;
        @(posedge clk);
        was_valid = model_valid;
        for (int c = 0; c < NCH; c++) begin
            prev_en[c] = !m_gated[c];
            act = b[c] | f[c] | w[c];
            if (r) begin
                m_gated[c] = 1'b0; m_idle[c] = 0; m_wake[c] = 0;
            end else if (m_wake[c] > 0) begin
                m_wake[c]--;
            end else if (m_gated[c]) begin
                if (act) begin
                    m_gated[c] = 1'b0;
                    m_wake[c]  = WL;
                end
            end else if (act || t == 0) begin
                m_idle[c] = 0;
            end else begin
                m_idle[c] = (m_idle[c] < 255) ? m_idle[c] + 1 : 255;
                if (m_idle[c] >= int'(t)) begin
                    m_gated[c] = 1'b1;
                    m_idle[c]  = 0;
                end
            end
        end
        if (r) model_valid = 1'b1;
        #1;
        if (was_valid) check("clk_o_high_phase", 32'(clk_g), 32'(prev_en | {NCH{s}}));
        @(negedge clk);
        if (model_valid) begin
            for (int c = 0; c < NCH; c++) begin
                exp_rdy[c] = !m_gated[c] && (m_wake[c] == 0);
                exp_g[c]   = m_gated[c];
            end
            check("ready_o", 32'(ready), 32'(exp_rdy));
            check("gated_o", 32'(gated), 32'(exp_g));
        end
    endtask

    initial begin
        logic [7:0]     rt;
        logic [NCH-1:0] rb, rf, rw;
        rst = 1'b1; scan = 1'b0; thr = 8'd3; busy = '0; force_on = '0; wake = '0;

        // Reset, then ch0 idles with threshold 3 while ch1-3 stay busy.
        step(1, 0, 3, 4'b1110, 0, 0);
        step(1, 0, 3, 4'b1110, 0, 0);
        check("reset_ready", 32'(ready), 32'hF);
        check("reset_gated", 32'(gated), 32'h0);
        step(0, 0, 3, 4'b1110, 0, 0);
        step(0, 0, 3, 4'b1110, 0, 0);
        check("ch0_not_yet_gated", 32'(gated[0]), 32'h0);
        step(0, 0, 3, 4'b1110, 0, 0);
        check("ch0_gated_at_3rd", 32'(gated[0]), 32'h1);
        repeat (4) step(0, 0, 3, 4'b1110, 0, 0);

        // One-cycle wake request, then re-gating after 3 idle cycles.
        step(0, 0, 3, 4'b1110, 0, 4'b0001);
        check("ch0_waking_not_ready", 32'(ready[0]), 32'h0);
        step(0, 0, 3, 4'b1110, 0, 0);
        step(0, 0, 3, 4'b1110, 0, 0);
        check("ch0_ready_at_w2", 32'(ready[0]), 32'h1);
        repeat (6) step(0, 0, 3, 4'b1110, 0, 0);

        // Threshold 4 with activity every 3rd cycle: never gates.
        step(0, 0, 4, 4'b1111, 0, 0);
        for (int i = 0; i < 30; i++) step(0, 0, 4, (i % 3 == 2) ? 4'b1111 : 4'b1110, 0, 0);
        check("pulsed_never_gates", 32'(gated[0]), 32'h0);

        // Threshold 0: nothing gates.
        repeat (300) step(0, 0, 0, 0, 0, 0);
        check("thresh0_no_gate", 32'(gated), 32'h0);

        // Gate ch2, then scan override.
        repeat (3) step(0, 0, 2, 4'b1011, 0, 0);
        repeat (4) step(0, 1, 2, 4'b1011, 0, 0);
        check("scan_gated_kept", 32'(gated[2]), 32'h1);
        check("scan_ready_kept", 32'(ready[2]), 32'h0);
        step(0, 0, 2, 4'b1111, 0, 0);

        // Reset while ch3 is in WAKE.
        repeat (3) step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 4'b1000);
        step(1, 0, 1, 0, 0, 0);
        check("rst_in_wake_ready", 32'(ready[3]), 32'h1);
        repeat (3) step(0, 0, 0, 4'b1000, 0, 0);

        // Randomized traffic.
        rt = 8'd3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) rt = 8'($urandom_range(0, 6));
            for (int c = 0; c < NCH; c++) begin
                rb[c] = ($urandom_range(0, 4) == 0);
                rf[c] = ($urandom_range(0, 19) == 0);
                rw[c] = ($urandom_range(0, 29) == 0);
            end
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0), rt, rb, rf, rw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
